// File: rtl/dmr_response_splitter.sv
// DMR return path: masks compared requests, tracks outstanding OBI transactions and
// replicates bus responses to all harts. Optional macro: DMR_RESP_ERR_CNT_EN (err_count_o).
package dmr_obi_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module dmr_response_splitter
  import dmr_obi_pkg::*;
#(
  parameter int NHARTS          = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  obi_req_t                compared_core_instr_req_i,
  input  obi_req_t                compared_core_data_req_i,
  output obi_req_t                bus_instr_req_o,
  output obi_req_t                bus_data_req_o,
  input  obi_resp_t               bus_instr_resp_i,
  input  obi_resp_t               bus_data_resp_i,
  output obi_resp_t [NHARTS-1:0]  core_instr_resp_o,
  output obi_resp_t [NHARTS-1:0]  core_data_resp_o,
  input  logic                    error_i,
  output logic                    recovery_req_o,
  input  logic                    recovery_ack_i,
  output logic                    blocked_o,
`ifdef DMR_RESP_ERR_CNT_EN
  output logic [7:0]              err_count_o,
`endif
  output logic                    protocol_err_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    RECOVER = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_i_q, cnt_i_d;
  logic [CW-1:0] cnt_d_q, cnt_d_d;
  logic          rec_q, rec_d;
  logic          blocked_q, blocked_d;
  logic          perr_q, perr_d;
  logic          allow_i, allow_d;
  logic          hs_i, hs_d;

  // A simultaneous grant and response leave the count unchanged.
  function automatic logic [CW-1:0] next_cnt(
    input logic [CW-1:0] cnt,
    input logic          hs,
    input logic          rv
  );
    if (hs && !rv) return cnt + CW'(1);
    if (rv && !hs && cnt != '0) return cnt - CW'(1);
    return cnt;
  endfunction

  assign allow_i = (state_q == RUN) && (cnt_i_q < MAX_CNT) && !error_i;
  assign allow_d = (state_q == RUN) && (cnt_d_q < MAX_CNT) && !error_i;

  always_comb begin
    bus_instr_req_o     = compared_core_instr_req_i;
    bus_instr_req_o.req = compared_core_instr_req_i.req & allow_i;
    bus_data_req_o      = compared_core_data_req_i;
    bus_data_req_o.req  = compared_core_data_req_i.req & allow_d;
  end

  assign hs_i = bus_instr_req_o.req & bus_instr_resp_i.gnt;
  assign hs_d = bus_data_req_o.req & bus_data_resp_i.gnt;

  always_comb begin
    for (int h = 0; h < NHARTS; h++) begin
      core_instr_resp_o[h]     = bus_instr_resp_i;
      core_instr_resp_o[h].gnt = hs_i;
      core_data_resp_o[h]      = bus_data_resp_i;
      core_data_resp_o[h].gnt  = hs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (error_i) state_d = DRAIN;
      DRAIN:   if (cnt_i_q == '0 && cnt_d_q == '0) state_d = RECOVER;
      RECOVER: if (recovery_ack_i) state_d = RUN;
      default: state_d = RUN;
    endcase
    cnt_i_d   = next_cnt(cnt_i_q, hs_i, bus_instr_resp_i.rvalid);
    cnt_d_d   = next_cnt(cnt_d_q, hs_d, bus_data_resp_i.rvalid);
    rec_d     = (state_d == RECOVER);
    blocked_d = (state_d != RUN);
    perr_d    = perr_q
              | (bus_instr_resp_i.rvalid && cnt_i_q == '0)
              | (bus_data_resp_i.rvalid && cnt_d_q == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      cnt_i_q   <= '0;
      cnt_d_q   <= '0;
      rec_q     <= 1'b0;
      blocked_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_i_q   <= cnt_i_d;
      cnt_d_q   <= cnt_d_d;
      rec_q     <= rec_d;
      blocked_q <= blocked_d;
      perr_q    <= perr_d;
    end
  end

  assign recovery_req_o = rec_q;
  assign blocked_o      = blocked_q;
  assign protocol_err_o = perr_q;

`ifdef DMR_RESP_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Counts error episodes, saturating at the top.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (state_q == RUN && error_i && err_cnt_q != 8'hFF)
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) err_cnt_q <= 8'd0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_count_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_dmr_response_splitter.sv
// Randomized bench for dmr_response_splitter against a transaction-level model.
module tb_dmr_response_splitter;
  import dmr_obi_pkg::*;

  localparam int MAXO = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic      rst;
  obi_req_t  ireq, dreq, bus_ireq, bus_dreq;
  obi_resp_t iresp, dresp;
  obi_resp_t [1:0] core_i, core_d;
  logic      err, rec_req, ack, blocked, perr;
`ifdef DMR_RESP_ERR_CNT_EN
  logic [7:0] ecnt;
`endif

  dmr_response_splitter #(.NHARTS(2), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i                     (clk),
    .rst_i                     (rst),
    .compared_core_instr_req_i (ireq),
    .compared_core_data_req_i  (dreq),
    .bus_instr_req_o           (bus_ireq),
    .bus_data_req_o            (bus_dreq),
    .bus_instr_resp_i          (iresp),
    .bus_data_resp_i           (dresp),
    .core_instr_resp_o         (core_i),
    .core_data_resp_o          (core_d),
    .error_i                   (err),
    .recovery_req_o            (rec_req),
    .recovery_ack_i            (ack),
    .blocked_o                 (blocked),
`ifdef DMR_RESP_ERR_CNT_EN
    .err_count_o               (ecnt),
`endif
    .protocol_err_o            (perr)
  );

  int n_cmp = 0;
  int n_err = 0;

  // stimulus for the next cycle
  bit          s_req[2], s_gnt[2], s_rv[2];
  logic [31:0] s_rdata[2];
  bit          s_err, s_ack, s_rst;

  // model: outstanding transactions per channel and episode phase
  int m_out[2];
  bit m_drain, m_recover, m_perr;
  int m_ecnt;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    for (int c = 0; c < 2; c++) begin
      s_req[c] = 0; s_gnt[c] = 0; s_rv[c] = 0; s_rdata[c] = $urandom;
    end
    s_err = 0; s_ack = 0; s_rst = 0;
  endtask

  task automatic model_reset();
    m_out[0] = 0; m_out[1] = 0;
    m_drain = 0; m_recover = 0; m_perr = 0; m_ecnt = 0;
  endtask

  task automatic step();
    bit run;
    bit allow[2], fire[2];
    int old[2];
    @(negedge clk);
    ireq = '{req: s_req[0], we: 1'b0, be: 4'hF, addr: $urandom, wdata: $urandom};
    dreq = '{req: s_req[1], we: 1'($urandom), be: 4'($urandom),
             addr: $urandom, wdata: $urandom};
    iresp = '{gnt: s_gnt[0], rvalid: s_rv[0], rdata: s_rdata[0]};
    dresp = '{gnt: s_gnt[1], rvalid: s_rv[1], rdata: s_rdata[1]};
    err = s_err; ack = s_ack; rst = s_rst;
    #1;
    run = !m_drain && !m_recover;
    for (int c = 0; c < 2; c++) begin
      allow[c] = run && m_out[c] < MAXO && !s_err;
      fire[c]  = s_req[c] && allow[c] && s_gnt[c];
    end
    check("i_bus_req", bus_ireq.req, s_req[0] && allow[0]);
    check("d_bus_req", bus_dreq.req, s_req[1] && allow[1]);
    check("i_bus_addr", bus_ireq.addr, ireq.addr);
    check("d_bus_wdata", bus_dreq.wdata, dreq.wdata);
    for (int h = 0; h < 2; h++) begin
      check("i_core_gnt", core_i[h].gnt, fire[0]);
      check("d_core_gnt", core_d[h].gnt, fire[1]);
      check("i_core_rvalid", core_i[h].rvalid, s_rv[0]);
      check("d_core_rvalid", core_d[h].rvalid, s_rv[1]);
      check("i_core_rdata", core_i[h].rdata, s_rdata[0]);
      check("d_core_rdata", core_d[h].rdata, s_rdata[1]);
    end
    if (s_rst) model_reset();
    else begin
      old = m_out;
      for (int c = 0; c < 2; c++) begin
        if (s_rv[c] && old[c] == 0) m_perr = 1;
        if (fire[c] && !s_rv[c]) m_out[c]++;
        else if (s_rv[c] && !fire[c] && old[c] > 0) m_out[c]--;
      end
      if (run) begin
        if (s_err) begin
          m_drain = 1;
          if (m_ecnt < 255) m_ecnt++;
        end
      end else if (m_drain) begin
        if (old[0] == 0 && old[1] == 0) begin
          m_drain = 0; m_recover = 1;
        end
      end else if (s_ack) m_recover = 0;
    end
    @(posedge clk); #1;
    check("blocked", blocked, m_drain || m_recover);
    check("recovery_req", rec_req, m_recover);
    check("protocol_err", perr, m_perr);
`ifdef DMR_RESP_ERR_CNT_EN
    check("err_count", ecnt, m_ecnt);
`endif
  endtask

  initial begin
    idle();
    ireq = '0; dreq = '0; iresp = '0; dresp = '0;
    err = 0; ack = 0; rst = 1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("rst_blocked", blocked, 0);
    check("rst_recovery_req", rec_req, 0);
    check("rst_protocol_err", perr, 0);

    // normal flow: grant, gap, response
    idle(); s_req[0] = 1; s_gnt[0] = 1; step();
    idle(); step();
    idle(); s_rv[0] = 1; s_rdata[0] = 32'hDEADBEEF; step();
    check("flow_blocked", blocked, 0);

    // limit: third data request masked, response re-enables
    repeat (3) begin idle(); s_req[1] = 1; s_gnt[1] = 1; step(); end
    idle(); s_req[1] = 1; s_gnt[1] = 1; s_rv[1] = 1; step();
    idle(); s_req[1] = 1; s_gnt[1] = 1; step();
    check("limit_reenable", m_out[1], 2);
    repeat (2) begin idle(); s_rv[1] = 1; step(); end

    // error with two outstanding
    repeat (2) begin idle(); s_req[1] = 1; s_gnt[1] = 1; step(); end
    idle(); s_err = 1; step();
    check("err2_blocked", blocked, 1);
    idle(); s_rv[1] = 1; s_req[0] = 1; s_gnt[0] = 1; step();
    idle(); s_rv[1] = 1; step();
    check("err2_still_drain", rec_req, 0);
    idle(); step();
    check("err2_recover", rec_req, 1);
    idle(); s_ack = 1; step();
    check("err2_run", blocked, 0);

    // error with zero outstanding plus rvalid and gnt together
    idle(); s_err = 1; s_req[0] = 1; s_gnt[0] = 1; s_rv[0] = 1; step();
    idle(); s_req[0] = 1; s_gnt[0] = 1; step();
    check("err0_recover", rec_req, 1);
    idle(); s_err = 1; step();
    idle(); s_ack = 1; step();

    // spurious flag sticks; reset during recovery
    check("spurious_sticky", perr, 1);
    idle(); s_err = 1; step();
    idle(); step();
    idle(); s_rst = 1; step();
    check("rst_rec_req", rec_req, 0);
    check("rst_perr", perr, 0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      idle();
      for (int c = 0; c < 2; c++) begin
        s_req[c] = ($urandom_range(0, 9) < 7);
        s_gnt[c] = ($urandom_range(0, 9) < 7);
        s_rv[c]  = (m_out[c] > 0) ? ($urandom_range(0, 1) == 1)
                                  : ($urandom_range(0, 399) == 0);
      end
      s_err = ($urandom_range(0, 39) == 0);
      s_ack = ($urandom_range(0, 3) == 0);
      s_rst = ($urandom_range(0, 499) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmr_response_splitter.md
Name: dmr_response_splitter

Overview:
- Return-path companion to the DMR request comparator. Sits between the compared OBI request streams (instr, data) and the bus, and fans single bus responses back out to all lockstepped harts.
- Tracks outstanding transactions per channel. On a comparator error it blocks new requests, drains in-flight responses, then runs a recovery handshake with the safety controller.

Parameters:
- NHARTS, 2, number of lockstepped cores receiving replicated responses.
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered transactions per channel; counter width is $clog2(MAX_OUTSTANDING+1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- compared_core_instr_req_i  in  obi_req_t  instr request from comparator.
- compared_core_data_req_i  in  obi_req_t  data request from comparator.
- bus_instr_req_o  out  obi_req_t  instr request to bus (req may be masked).
- bus_data_req_o  out  obi_req_t  data request to bus (req may be masked).
- bus_instr_resp_i  in  obi_resp_t  instr response from bus.
- bus_data_resp_i  in  obi_resp_t  data response from bus.
- core_instr_resp_o  out  obi_resp_t[NHARTS]  replicated instr responses.
- core_data_resp_o  out  obi_resp_t[NHARTS]  replicated data responses.
- error_i  in  1  comparator mismatch flag.
- recovery_req_o  out  1  level request to safety controller.
- recovery_ack_i  in  1  recovery done pulse.
- blocked_o  out  1  high whenever the state is not RUN.
- protocol_err_o  out  1  sticky flag: rvalid received with zero outstanding.

Behaviour:
- Reset (rst_i=1 at clk_i edge): state RUN, both counters 0, recovery_req_o=0, protocol_err_o=0, blocked_o=0. Applies mid-drain or mid-recovery too; in-flight responses arriving after reset count as spurious.
- Request path is combinational. bus_*_req_o equals compared_*_req_i, except req is forced 0 when req_allow=0.
- req_allow per channel = (state==RUN) && (count < MAX_OUTSTANDING) && !error_i.
- Response path is combinational with zero latency. Every hart gets identical rdata and rvalid from the bus. gnt to each hart = bus gnt && the masked bus req.
- Counters, per channel:
  - +1 on (bus req && gnt); -1 on rvalid.
  - Both in one cycle: count unchanged.
  - Never exceeds MAX_OUTSTANDING, because req is masked at the limit.
- Spurious rvalid (rvalid with count==0): still forwarded to the cores, count stays 0, protocol_err_o set until reset.
- State machine:
  - RUN: error_i=1 -> DRAIN, regardless of counts.
  - DRAIN: all requests masked; rvalid still forwarded and decremented. Leaves for RECOVER once both counts==0, evaluated on registered counts. Minimum DRAIN dwell is 1 cycle. Deassertion of error_i does not shorten DRAIN.
  - RECOVER: recovery_req_o=1 (registered) and requests masked. recovery_ack_i=1 -> RUN next cycle, recovery_req_o=0. error_i is ignored in this state.
- recovery_ack_i is ignored outside RECOVER.
- blocked_o = (state != RUN), registered.

Optional Feature:
- Macro: DMR_RESP_ERR_CNT_EN.
- Defined: adds output err_count_o, 8 bits, reset 0. It increments on every RUN->DRAIN transition and saturates at 255.
- Not defined: the port is absent, and no counter logic is built.

Test Plan:
- Normal flow: instr req with gnt=1 in cycle 0, rvalid with rdata=0xDEADBEEF in cycle 2 -> both harts see gnt in cycle 0 and rdata 0xDEADBEEF in cycle 2; count goes 0->1->0; blocked_o=0 throughout.
- Limit: MAX_OUTSTANDING=2, three back-to-back data reqs with bus gnt tied 1 and no rvalid -> third request has bus req=0 and core gnt=0. One rvalid then re-enables req.
- Error with 2 outstanding: pulse error_i for 1 cycle -> DRAIN, bus reqs 0. After two rvalids, RECOVER and recovery_req_o=1. ack pulse -> RUN next cycle with recovery_req_o=0.
- Error with 0 outstanding and simultaneous rvalid+gnt in DRAIN entry cycle -> DRAIN lasts exactly 1 cycle beyond count settle, then RECOVER.
- Spurious rvalid with count 0 -> forwarded to both harts, protocol_err_o=1 until rst_i. Applying rst_i in RECOVER -> RUN with recovery_req_o=0 next cycle.
- DMR_RESP_ERR_CNT_EN: 3 error episodes -> err_count_o=3. An error_i pulse during RECOVER does not increment it.
